// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one DATA_WIDTH-bit full-duplex transfer per accepted start, MSB first.
// SCLK is derived from clk by counting CLK_DIV clk cycles per SCLK half-period.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BITW = $clog2(DATA_WIDTH + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DIVW-1:0]       divCnt_q, divCnt_d;
    logic [BITW-1:0]       bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
    logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d;
    logic [DATA_WIDTH-1:0] rxData_q, rxData_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  divLast;

    assign divLast = (divCnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            bitCnt_q  <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            bitCnt_q  <= bitCnt_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rxData_q  <= rxData_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Every phase lasts a whole number of CLK_DIV-cycle slots; divLast marks a slot's final edge.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        bitCnt_d  = bitCnt_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rxData_d  = rxData_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    txShift_d = masterDataToSend;
                    mosi_d    = masterDataToSend[DATA_WIDTH-1];
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    divCnt_d  = '0;
                    bitCnt_d  = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                divCnt_d = divLast ? '0 : divCnt_q + DIVW'(1);
                if (divLast) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                divCnt_d = divLast ? '0 : divCnt_q + DIVW'(1);
                if (divLast) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rxShift_d = {rxShift_q[DATA_WIDTH-2:0], MISO};
                        bitCnt_d  = bitCnt_q + BITW'(1);
                    end else if (bitCnt_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        // The falling edge gives the slave a full half-period to see the next bit.
                        txShift_d = txShift_q << 1;
                        mosi_d    = txShift_q[DATA_WIDTH-2];
                    end
                end
            end
            HOLD: begin
                divCnt_d = divLast ? '0 : divCnt_q + DIVW'(1);
                if (divLast) begin
                    cs_d     = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    rxData_d = rxShift_q;
                    mosi_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign masterDataReceived = rxData_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign SCLK               = sclk_q;
    assign CS                 = cs_q;
    assign MOSI               = mosi_q;

endmodule
